mul_repadd: RTL and testbench

Parametrised sequential multiplier that computes an unsigned product by repeated addition. It takes over from the hand-wired multiplier datapath and its separate controller: the accumulator, multiplicand register, down-counter, zero detector and control FSM live in one block. It sits behind a start/done handshake so any master can issue a multiply and wait for a one-cycle completion pulse. The product is full width (2×W), so it never overflows.

---
 rtl/mul_repadd.sv | 113 +++++++++++
 tb/tb_mul_repadd.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mul_repadd.sv
// mul_repadd: unsigned sequential multiplier by repeated addition.
// The accumulator P gains A once per ADD cycle while the down-counter B
// is non-zero, so the product is ready after B additions.
// Optional feature macro: MUL_SWAP_EN. When defined, the larger operand
// is loaded as the addend and the smaller as the count, so the number of
// additions is min(a, b).
//
// Handshake: start is taken only on an edge where ready=1. Operands are
// sampled on that same edge and ignored at all other times. done is a
// one-cycle pulse and product is valid in that cycle. product then holds
// until the next accepted start.
module mul_repadd #(
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           ready,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product,
   output logic [1:0]     state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [2*W-1:0] p_q, p_d;
   logic [W-1:0]   load_a, load_b;

   // Select which operand is the addend and which is the addition count
   always_comb begin
`ifdef MUL_SWAP_EN
      if (b > a) begin
         load_a = b;
         load_b = a;
      end else begin
         load_a = a;
         load_b = b;
      end
`else
      load_a = a;
      load_b = b;
`endif
   end

   // Next-state, datapath update and handshake outputs
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      ready   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready = 1'b1;
            if (start) begin
               a_d     = load_a;
               b_d     = load_b;
               p_d     = '0;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            busy = 1'b1;
            if (b_q != '0) begin
               p_d = p_q + {{W{1'b0}}, a_q};
               b_d = b_q - W'(1);
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            // An unused encoding returns to IDLE on the next edge
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
      end
   end

   assign product   = p_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mul_repadd.sv
// tb_mul_repadd: self-checking bench for mul_repadd.
// It instantiates two copies, with W=16 and W=4. A shared driver task
// runs one multiply on the selected copy. Expected products come from
// plain a*b. Expected latency is the addition count plus two.
module tb_mul_repadd;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   int          sel = 0;          // 0: W=16 copy, 1: W=4 copy
   logic        start_x = 1'b0;
   logic [31:0] a_x = '0;
   logic [31:0] b_x = '0;

   logic        start16, start4;
   logic [15:0] a16, b16;
   logic [3:0]  a4, b4;
   logic        ready16, busy16, done16, ready4, busy4, done4;
   logic [31:0] product16;
   logic [7:0]  product4;
   logic [1:0]  state16, state4;

   assign start16 = (sel == 0) && start_x;
   assign start4  = (sel == 1) && start_x;
   assign a16 = a_x[15:0];
   assign b16 = b_x[15:0];
   assign a4  = a_x[3:0];
   assign b4  = b_x[3:0];

   logic        ready_o, busy_o, done_o;
   logic [63:0] product_o;
   assign ready_o   = (sel == 1) ? ready4 : ready16;
   assign busy_o    = (sel == 1) ? busy4  : busy16;
   assign done_o    = (sel == 1) ? done4  : done16;
   assign product_o = (sel == 1) ? {56'b0, product4} : {32'b0, product16};

   mul_repadd #(.W(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
      .ready(ready16), .busy(busy16), .done(done16),
      .product(product16), .state_dbg(state16)
   );

   mul_repadd #(.W(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
      .ready(ready4), .busy(busy4), .done(done4),
      .product(product4), .state_dbg(state4)
   );

   // ---------------- scoreboard ----------------
   logic [63:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: number of additions the multiplier should perform
   function automatic int model_n(input logic [31:0] av, input logic [31:0] bv);
`ifdef MUL_SWAP_EN
      return (av < bv) ? int'(av) : int'(bv);
`else
      return int'(bv);
`endif
   endfunction

   // ---------------- driver ----------------
   // Runs one multiply on the selected copy. The task is entered in a
   // sample slot where ready is expected high.
   // ign1/ign2: cycles in which a stray start pulse is driven.
   // rst_cyc > 0: assert reset during that cycle to abort the operation.
   task automatic run_mul(input string tag, input logic [31:0] av_in,
                          input logic [31:0] bv_in, input int ign1,
                          input int ign2, input int rst_cyc);
      logic [31:0] av, bv;
      int          n, lat, budget, cyc;
      int          done_cyc, done_cnt, busy_bad;
      logic [63:0] prod_at_done, exp_p;
      av = (sel == 1) ? (av_in & 32'hF) : (av_in & 32'hFFFF);
      bv = (sel == 1) ? (bv_in & 32'hF) : (bv_in & 32'hFFFF);
      n   = model_n(av, bv);
      lat = n + 2;
      budget = lat + 20;
      check_eq({tag, "_ready_before"}, {63'b0, ready_o}, 64'd1);
      start_x = 1'b1;
      a_x = av;
      b_x = bv;
      exp_q.push_back(64'(av) * 64'(bv));
      @(posedge clk); #1;
      start_x = 1'b0;
      a_x = $urandom;
      b_x = $urandom;
      cyc = 1;
      done_cyc = -1; done_cnt = 0; busy_bad = 0; prod_at_done = '0;
      while (!ready_o && cyc <= budget) begin
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            prod_at_done = product_o;
         end
         if (!busy_o) busy_bad++;
         start_x = (cyc == ign1) || (cyc == ign2);
         a_x = $urandom_range(1, 15);
         b_x = $urandom_range(1, 15);
         rst = (cyc == rst_cyc);
         @(posedge clk); #1;
         rst = 1'b0;
         start_x = 1'b0;
         cyc++;
      end
      check_eq({tag, "_ready_return"}, {63'b0, ready_o}, 64'd1);
      check_eq({tag, "_busy_at_ready"}, {63'b0, busy_o}, 64'd0);
      check_eq({tag, "_done_at_ready"}, {63'b0, done_o}, 64'd0);
      exp_p = exp_q.pop_front();
      if (rst_cyc > 0) begin
         check_eq({tag, "_abort_cyc"}, 64'(cyc), 64'(rst_cyc + 1));
         check_eq({tag, "_abort_no_done"}, 64'(done_cnt), 64'd0);
         check_eq({tag, "_abort_product"}, product_o, 64'd0);
      end else begin
         check_eq({tag, "_done_cyc"}, 64'(done_cyc), 64'(lat));
         check_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
         check_eq({tag, "_ready_cyc"}, 64'(cyc), 64'(lat + 1));
         check_eq({tag, "_busy_gap"}, 64'(busy_bad), 64'd0);
         check_eq({tag, "_product"}, prod_at_done, exp_p);
         check_eq({tag, "_product_held"}, product_o, exp_p);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (2) @(posedge clk);
      #1;
      // Reset values, checked while reset is still applied
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #0;
         check_eq($sformatf("rst_ready_%0d", s), {63'b0, ready_o}, 64'd1);
         check_eq($sformatf("rst_busy_%0d", s), {63'b0, busy_o}, 64'd0);
         check_eq($sformatf("rst_done_%0d", s), {63'b0, done_o}, 64'd0);
         check_eq($sformatf("rst_product_%0d", s), product_o, 64'd0);
      end
      rst = 1'b0;
      sel = 0;
      @(posedge clk); #1;

      // Directed W=16 cases
      run_mul("m7x5", 32'd7, 32'd5, 0, 0, 0);
      run_mul("m3x200", 32'd3, 32'd200, 0, 0, 0);
      run_mul("mffffx0", 32'hFFFF, 32'd0, 0, 0, 0);
      run_mul("m0x3", 32'd0, 32'd3, 0, 0, 0);
      run_mul("m9x9_ign", 32'd9, 32'd9, 3, 11, 0);
      run_mul("m_back2back", 32'd6, 32'd4, 0, 0, 0);
      run_mul("m10x50_rst", 32'd10, 32'd50, 0, 0, 20);
      run_mul("m4x4_after_rst", 32'd4, 32'd4, 0, 0, 0);
      run_mul("m_max_small", 32'hFFFF, 32'd3, 0, 0, 0);
      run_mul("m_max_large", 32'd2, 32'hFFFF, 0, 0, 0);

      // Randomized W=16 operands with a bounded addition count
      for (int i = 0; i < 20; i++) begin
         run_mul($sformatf("rnd16_%0d", i), $urandom,
                 32'($urandom_range(0, 300)), 0, 0, 0);
      end

      // W=4: the full-scale product needs all 8 bits, then the full sweep
      sel = 1;
      #0;
      run_mul("w4_15x15", 32'd15, 32'd15, 0, 0, 0);
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            run_mul($sformatf("w4_%0dx%0d", x, y), 32'(x), 32'(y), 0, 0, 0);
         end
      end

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
